// File: rtl/lane_background_painter.sv
// lane_background_painter
//
// Full-screen background painter that sits upstream of the top-level pixel
// multiplexer. When asked, it sweeps every pixel of the frame exactly once.
// The sweep runs in raster order at one pixel per clock. Each pixel is given
// the piano-lane pattern: white lane fill, black lane dividers, and an
// optional coloured hit band.
//
// Optional feature macro: LANE_HIT_BAND_EN
//   defined   : rows HIT_Y..HIT_Y+HIT_H-1 are painted HIT_COL on non-divider
//               pixels.
//   undefined : no hit band logic is built, so those rows paint BG_COL.
//               HIT_Y, HIT_H and HIT_COL are still declared but have no
//               effect. Frame length and timing are the same either way.
//
// Ports
//   clk        in   1  system clock
//   resetn     in   1  synchronous active-low reset
//   enable     in   1  level request to paint; held high until completed
//   x_out      out  8  pixel x coordinate (registered)
//   y_out      out  7  pixel y coordinate (registered)
//   col_out    out  3  pixel colour (registered)
//   plot       out  1  pixel write strobe; x/y/col valid when high
//   completed  out  1  frame fully painted; never high together with plot
module lane_background_painter #(
    parameter int         SCR_W   = 160,
    parameter int         SCR_H   = 120,
    parameter int         LANE_W  = 40,
    parameter logic [2:0] BG_COL  = 3'b111,
    parameter logic [2:0] DIV_COL = 3'b000,
    parameter int         HIT_Y   = 100,
    parameter int         HIT_H   = 8,
    parameter logic [2:0] HIT_COL = 3'b001
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] col_out,
    output logic       plot,
    output logic       completed
);

    localparam int LANE_BITS = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam logic [7:0]           X_LAST    = 8'(SCR_W - 1);
    localparam logic [6:0]           Y_LAST    = 7'(SCR_H - 1);
    localparam logic [LANE_BITS-1:0] LANE_LAST = LANE_BITS'(LANE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // r_x/r_y hold the pixel to be plotted on the next DRAW edge.
    // r_lane tracks x mod LANE_W so the divider test needs no divider.
    logic [7:0]           r_x;
    logic [6:0]           r_y;
    logic [LANE_BITS-1:0] r_lane;

    logic [7:0]           w_pixX;
    logic [6:0]           w_pixY;
    logic [LANE_BITS-1:0] w_pixLane;
    logic [7:0]           w_advX;
    logic [6:0]           w_advY;
    logic [LANE_BITS-1:0] w_advLane;
    logic                 w_lastCol;
    logic                 w_lastRow;
    logic                 w_isDivider;
    logic                 w_inBand;
    logic [2:0]           w_pixCol;

    logic [7:0]           w_xNext;
    logic [6:0]           w_yNext;
    logic [LANE_BITS-1:0] w_laneNext;
    logic [7:0]           w_xOutNext;
    logic [6:0]           w_yOutNext;
    logic [2:0]           w_colOutNext;
    logic                 w_plotNext;
    logic                 w_completedNext;

    // The pixel being issued is (0,0) when leaving IDLE.
    // In DRAW it is the pixel held in the counters.
    always_comb begin
        w_pixX    = '0;
        w_pixY    = '0;
        w_pixLane = '0;
        if (r_state == S_DRAW) begin
            w_pixX    = r_x;
            w_pixY    = r_y;
            w_pixLane = r_lane;
        end
    end

    // Raster advance. Each wrap is an explicit compare-and-clear, so the
    // counters never run past the frame edges.
    always_comb begin
        w_lastCol = (w_pixX == X_LAST);
        w_lastRow = (w_pixY == Y_LAST);
        w_advX    = '0;
        w_advY    = w_pixY;
        w_advLane = '0;
        if (w_lastCol) begin
            w_advY = w_lastRow ? 7'd0 : (w_pixY + 7'd1);
        end else begin
            w_advX    = w_pixX + 8'd1;
            w_advLane = (w_pixLane == LANE_LAST) ? '0 : (w_pixLane + 1'b1);
        end
    end

`ifdef LANE_HIT_BAND_EN
    localparam logic [7:0] BAND_LO = 8'(HIT_Y);
    localparam logic [7:0] BAND_HI = 8'(HIT_Y + HIT_H);

    always_comb begin
        w_inBand = ({1'b0, w_pixY} >= BAND_LO) && ({1'b0, w_pixY} < BAND_HI);
    end
`else
    // The band is not built. These parameters only feed a sink so they
    // stay declared without driving anything.
    logic w_unusedBand;
    assign w_unusedBand = ^{HIT_COL, 8'(HIT_Y), 8'(HIT_H)};

    always_comb begin
        w_inBand = 1'b0;
    end
`endif

    // Colour priority: divider, then hit band, then lane fill.
    always_comb begin
        w_isDivider = (w_pixLane == LANE_LAST);
        if (w_isDivider) begin
            w_pixCol = DIV_COL;
        end else if (w_inBand) begin
            w_pixCol = HIT_COL;
        end else begin
            w_pixCol = BG_COL;
        end
    end

    // Next state and next register values.
    // Outputs are registered on the same edge as the state change. The
    // first plot therefore appears on the cycle after enable is sampled.
    always_comb begin
        w_stateNext     = r_state;
        w_xNext         = '0;
        w_yNext         = '0;
        w_laneNext      = '0;
        w_xOutNext      = x_out;
        w_yOutNext      = y_out;
        w_colOutNext    = col_out;
        w_plotNext      = 1'b0;
        w_completedNext = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_stateNext  = S_DRAW;
                    w_plotNext   = 1'b1;
                    w_xOutNext   = w_pixX;
                    w_yOutNext   = w_pixY;
                    w_colOutNext = w_pixCol;
                    w_xNext      = w_advX;
                    w_yNext      = w_advY;
                    w_laneNext   = w_advLane;
                end
            end
            S_DRAW: begin
                if (!enable) begin
                    // Abort: counters clear so the next request restarts at (0,0).
                    w_stateNext = S_IDLE;
                end else begin
                    w_plotNext   = 1'b1;
                    w_xOutNext   = w_pixX;
                    w_yOutNext   = w_pixY;
                    w_colOutNext = w_pixCol;
                    if (w_lastCol && w_lastRow) begin
                        w_stateNext = S_DONE;
                    end else begin
                        w_xNext    = w_advX;
                        w_yNext    = w_advY;
                        w_laneNext = w_advLane;
                    end
                end
            end
            S_DONE: begin
                // Stay here while enable is high, so no repaint happens
                // until enable drops and rises again.
                if (enable) begin
                    w_completedNext = 1'b1;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x       <= '0;
            r_y       <= '0;
            r_lane    <= '0;
            x_out     <= '0;
            y_out     <= '0;
            col_out   <= '0;
            plot      <= 1'b0;
            completed <= 1'b0;
        end else begin
            r_x       <= w_xNext;
            r_y       <= w_yNext;
            r_lane    <= w_laneNext;
            x_out     <= w_xOutNext;
            y_out     <= w_yOutNext;
            col_out   <= w_colOutNext;
            plot      <= w_plotNext;
            completed <= w_completedNext;
        end
    end

endmodule

// File: tb/tb_lane_background_painter.sv
// tb_lane_background_painter
//
// Directed bench for lane_background_painter. Every time a frame is
// requested, the bench pushes the expected pixel stream into a scoreboard
// queue. Each plotted pixel pops one entry from the queue and is compared
// against it.
// The hit band expectations follow the LANE_HIT_BAND_EN macro.
module tb_lane_background_painter;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] col_out;
    logic       plot;
    logic       completed;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       expQ[$];
    int         vectors;
    int         miscompares;
    bit         capture;
    logic [2:0] frameCap [0:119][0:159];
    logic       prevPlot;
    logic       prevCompleted;
    logic [7:0] prevX;
    logic [6:0] prevY;

    lane_background_painter dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .x_out     (x_out),
        .y_out     (y_out),
        .col_out   (col_out),
        .plot      (plot),
        .completed (completed)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference colour: divider at x mod 40 == 39, then the optional band
    // at rows 100..107, otherwise white.
    function automatic logic [2:0] modelCol(input int x, input int y);
        if ((x % 40) == 39) return 3'b000;
`ifdef LANE_HIT_BAND_EN
        if (y >= 100 && y < 108) return 3'b001;
`endif
        return 3'b111;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic en);
        resetn = rstn;
        enable = en;
    endtask

    task automatic pushFrame();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                expQ.push_back({8'(x), 7'(y), modelCol(x, y)});
    endtask

    // One cycle: sample at the falling edge and score any plotted pixel.
    task automatic tick();
        pix_t exp;
        @(negedge clk);
        if (plot) begin
            exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
            checkOutput("pixel", {x_out, y_out, col_out}, exp);
            if (capture && x_out < 8'd160 && y_out < 7'd120)
                frameCap[y_out][x_out] = col_out;
        end
        checkOutput("plotCompletedExclusive", {31'd0, plot & completed}, 32'd0);
        if (completed && !prevCompleted)
            checkOutput("doneAfterLast", {prevPlot, prevX, prevY}, {1'b1, 8'd159, 7'd119});
        prevPlot      = plot;
        prevCompleted = completed;
        prevX         = x_out;
        prevY         = y_out;
    endtask

    task automatic runFrame(input string tag);
        int plots = 0;
        bit seen  = 0;
        tick();
        checkOutput({tag, "First"}, {plot, x_out, y_out, col_out}, {1'b1, 8'd0, 7'd0, 3'b111});
        if (plot) plots++;
        for (int n = 0; n < 20000; n++) begin
            tick();
            if (plot) plots++;
            if (completed) begin
                seen = 1;
                break;
            end
        end
        checkOutput({tag, "Completed"}, {31'd0, seen}, 32'd1);
        checkOutput({tag, "Plots"}, plots, 19200);
        checkOutput({tag, "QueueEmpty"}, expQ.size(), 0);
    endtask

    task automatic runPlots(input string tag, input int target);
        int plots = 0;
        tick();
        checkOutput({tag, "First"}, {plot, x_out, y_out, col_out}, {1'b1, 8'd0, 7'd0, 3'b111});
        if (plot) plots++;
        for (int n = 0; n < target + 100 && plots < target; n++) begin
            tick();
            if (plot) plots++;
        end
        checkOutput({tag, "Count"}, plots, target);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "X"}, x_out, 0);
        checkOutput({tag, "Y"}, y_out, 0);
        checkOutput({tag, "Col"}, col_out, 0);
        checkOutput({tag, "Plot"}, plot, 0);
        checkOutput({tag, "Completed"}, completed, 0);
    endtask

    initial begin
        int holdPlots;
        int holdLow;
        logic [2:0] bandExp;
        vectors       = 0;
        miscompares   = 0;
        capture       = 0;
        prevPlot      = 0;
        prevCompleted = 0;
        prevX         = '0;
        prevY         = '0;
`ifdef LANE_HIT_BAND_EN
        bandExp = 3'b001;
`else
        bandExp = 3'b111;
`endif
        $display("[TB] start");

        // Reset, including enable high while reset is held.
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        tick();
        checkAllZero("reset");

        // First full frame, captured for spot checks.
        applyStimulus(1'b1, 1'b1);
        pushFrame();
        capture = 1;
        runFrame("frame1");
        capture = 0;
        checkOutput("pix39_50", frameCap[50][39], 3'b000);
        checkOutput("pix10_100", frameCap[100][10], bandExp);
        checkOutput("pix10_107", frameCap[107][10], bandExp);
        checkOutput("pix10_108", frameCap[108][10], 3'b111);
        checkOutput("pix79_103", frameCap[103][79], 3'b000);

        // Drop enable in DONE.
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("idleCompleted", completed, 0);
        checkOutput("idlePlot", plot, 0);

        // Abort after 500 plots, then restart a full frame.
        applyStimulus(1'b1, 1'b1);
        pushFrame();
        runPlots("abort", 500);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("abortPlot", plot, 0);
        checkOutput("abortCompleted", completed, 0);
        expQ.delete();
        tick();
        applyStimulus(1'b1, 1'b1);
        pushFrame();
        runFrame("restart");

        // Hold enable high in DONE: no repaint.
        holdPlots = 0;
        holdLow   = 0;
        repeat (100) begin
            tick();
            if (plot) holdPlots++;
            if (!completed) holdLow++;
        end
        checkOutput("holdNoPlot", holdPlots, 0);
        checkOutput("holdCompletedLow", holdLow, 0);
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("dropCompleted", completed, 0);

        // Fresh frame, interrupted by reset at pixel 7000.
        applyStimulus(1'b1, 1'b1);
        pushFrame();
        runPlots("fresh", 7000);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkAllZero("midReset");
        expQ.delete();
        applyStimulus(1'b1, 1'b1);
        pushFrame();
        runFrame("afterReset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
